jesd_rx_link_sync: RTL and testbench

Receive-side JESD204B data-link synchronizer for one lane, one octet per clock, placed between the lane's 8b/10b decoder and the RX transport layer. It implements code-group synchronization (CGS), drives SYNC~, and checks the initial lane alignment sequence (ILAS). It also reverses the transmitter's /F/ and /A/ character replacement before delivering frame-aligned octets downstream.

---
 rtl/jesd_rx_pkg.sv | 22 ++
 rtl/jesd_rx_link_sync_if.sv | 40 ++++
 rtl/jesd_rx_char_restore.sv | 59 +++++
 rtl/jesd_rx_link_sync.sv | 209 ++++++++++++++++++++
 tb/tb_jesd_rx_link_sync.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/jesd_rx_pkg.sv
// Shared definitions for the JESD204B receive link synchronizer.
// Holds the control-character codes, the link state enum, the error threshold
// and the number of consecutive /K/ needed to finish code-group synchronization.
package jesd_rx_pkg;

  localparam logic [7:0] CharK = 8'hBC;  // K28.5
  localparam logic [7:0] CharR = 8'h1C;  // K28.0
  localparam logic [7:0] CharA = 8'h7C;  // K28.3
  localparam logic [7:0] CharQ = 8'h9C;  // K28.4
  localparam logic [7:0] CharF = 8'hFC;  // K28.7

  localparam int unsigned ErrThreshold = 3;
  localparam int unsigned CgsCount     = 4;

  typedef enum logic [1:0] {
    CS_INIT,
    CS_CHECK,
    ILAS,
    DATA
  } link_state_e;

endpackage

// File: rtl/jesd_rx_link_sync_if.sv
// Lane-side and transport-side signals of the RX link synchronizer.
//   rx_data/rx_charisk/rx_disperr/rx_notintable : decoded octet from the 8b/10b decoder
//   sync_n                                     : SYNC~ towards the transmitter
//   data_out/data_valid/frame_end               : restored octets towards the transport layer
//   ilas_done/ilas_err/align_err                : link status
//   ilas_cfg                                    : captured ILAS config octets, only when
//                                                 JESD_RX_ILAS_CFG_CAPTURE_EN is defined
// The master modport is the decoder/transport side, the slave modport is the synchronizer.
interface jesd_rx_link_sync_if;
  logic [7:0] rx_data;
  logic       rx_charisk;
  logic       rx_disperr;
  logic       rx_notintable;
  logic       sync_n;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_end;
  logic       ilas_done;
  logic       ilas_err;
  logic       align_err;
`ifdef JESD_RX_ILAS_CFG_CAPTURE_EN
  logic [111:0] ilas_cfg;
`endif

  modport master (
    output rx_data, rx_charisk, rx_disperr, rx_notintable,
    input  sync_n, data_out, data_valid, frame_end, ilas_done, ilas_err, align_err
`ifdef JESD_RX_ILAS_CFG_CAPTURE_EN
    , input ilas_cfg
`endif
  );

  modport slave (
    input  rx_data, rx_charisk, rx_disperr, rx_notintable,
    output sync_n, data_out, data_valid, frame_end, ilas_done, ilas_err, align_err
`ifdef JESD_RX_ILAS_CFG_CAPTURE_EN
    , output ilas_cfg
`endif
  );
endinterface

// File: rtl/jesd_rx_char_restore.sv
// Undoes the transmitter's /F/ and /A/ character replacement in the data phase.
//   clock, reset      : clock and asynchronous active-low reset
//   state_i, pos_i    : link state and octet position within the multiframe
//   rx_data_i, rx_charisk_i, octet_ok_i : current octet and its validity
//   restored_o        : octet to deliver downstream
//   replace_o         : octet is a correctly placed /F/ or /A/
//   misplaced_o       : octet is an /F/ or /A/ anywhere else
//   frame_end_pos_o   : pos_i is the last octet of a frame
module jesd_rx_char_restore
  import jesd_rx_pkg::*;
#(
  parameter int unsigned F = 2,
  parameter int unsigned K = 32,
  localparam int unsigned PW = $clog2(F * K)
) (
  input  logic          clock,
  input  logic          reset,
  input  link_state_e   state_i,
  input  logic [PW-1:0] pos_i,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_charisk_i,
  input  logic          octet_ok_i,
  output logic [7:0]    restored_o,
  output logic          replace_o,
  output logic          misplaced_o,
  output logic          frame_end_pos_o
);

  logic [7:0] last_q, last_d;
  logic       in_data, mf_end, is_a, is_f;

  always_comb begin
    in_data         = (state_i == DATA);
    frame_end_pos_o = ((int'(pos_i) % int'(F)) == (int'(F) - 1));
    mf_end          = (pos_i == PW'(F * K - 1));
    is_a            = octet_ok_i && rx_charisk_i && (rx_data_i == CharA);
    is_f            = octet_ok_i && rx_charisk_i && (rx_data_i == CharF);
    replace_o       = in_data && ((mf_end && is_a) || (frame_end_pos_o && !mf_end && is_f));
    misplaced_o     = in_data && (is_a || is_f) && !replace_o;
    restored_o      = (replace_o || misplaced_o) ? last_q : rx_data_i;

    // Only a genuine data octet at a frame end becomes the new replacement value.
    last_d = last_q;
    if (!in_data) begin
      last_d = 8'h00;
    end else if (frame_end_pos_o && !rx_charisk_i && octet_ok_i) begin
      last_d = rx_data_i;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q <= 8'h00;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/jesd_rx_link_sync.sv
// JESD204B receive data-link synchronizer for one lane, one octet per clock.
// Runs code-group synchronization, drives SYNC~, checks the ILAS and restores
// /F/ and /A/ replaced octets in the data phase. Monitors link errors in the
// data phase and drops back to CS_INIT after ErrThreshold net errors.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   bus          : jesd_rx_link_sync_if.slave (lane input, transport output, status)
// Optional: JESD_RX_ILAS_CFG_CAPTURE_EN checks /Q/ at p=1 of ILAS multiframe 1
// and captures octets p=2..15 of that multiframe into bus.ilas_cfg.
module jesd_rx_link_sync
  import jesd_rx_pkg::*;
#(
  parameter int unsigned F                = 2,
  parameter int unsigned K                = 32,
  parameter int unsigned ILAS_MULTIFRAMES = 4
) (
  input logic               clock,
  input logic               reset,
  jesd_rx_link_sync_if.slave bus
);

  localparam int unsigned FK = F * K;
  localparam int unsigned PW = $clog2(FK);
  localparam int unsigned MW = (ILAS_MULTIFRAMES > 1) ? $clog2(ILAS_MULTIFRAMES) : 1;

  link_state_e   state_q, state_d;
  logic [PW-1:0] pos_q, pos_d, pos_next;
  logic [MW-1:0] mf_q, mf_d;
  logic [1:0]    cgs_q, cgs_d;
  logic [1:0]    err_q, err_d;
  logic [1:0]    good_q, good_d;

  logic       sync_n_q, data_valid_q, frame_end_q, ilas_done_q, ilas_err_q, align_err_q;
  logic [7:0] data_out_q;

  logic       octet_ok, is_k, is_r, is_a, last_pos, in_data;
  logic       ilas_fail, data_err;
  logic [7:0] restored;
  logic       replace, misplaced, frame_end_pos;

`ifdef JESD_RX_ILAS_CFG_CAPTURE_EN
  logic [111:0] cfg_q, cfg_d;
  logic         is_q;
  assign is_q = octet_ok && bus.rx_charisk && (bus.rx_data == CharQ);
`endif

  assign octet_ok = !bus.rx_disperr && !bus.rx_notintable;
  assign is_k     = octet_ok && bus.rx_charisk && (bus.rx_data == CharK);
  assign is_r     = octet_ok && bus.rx_charisk && (bus.rx_data == CharR);
  assign is_a     = octet_ok && bus.rx_charisk && (bus.rx_data == CharA);
  assign last_pos = (pos_q == PW'(FK - 1));
  assign pos_next = last_pos ? '0 : pos_q + 1'b1;
  assign in_data  = (state_q == DATA);

  jesd_rx_char_restore #(
    .F (F),
    .K (K)
  ) u_char_restore (
    .clock           (clock),
    .reset           (reset),
    .state_i         (state_q),
    .pos_i           (pos_q),
    .rx_data_i       (bus.rx_data),
    .rx_charisk_i    (bus.rx_charisk),
    .octet_ok_i      (octet_ok),
    .restored_o      (restored),
    .replace_o       (replace),
    .misplaced_o     (misplaced),
    .frame_end_pos_o (frame_end_pos)
  );

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    mf_d      = mf_q;
    cgs_d     = cgs_q;
    err_d     = err_q;
    good_d    = good_q;
    ilas_fail = 1'b0;
    data_err  = 1'b0;
`ifdef JESD_RX_ILAS_CFG_CAPTURE_EN
    cfg_d     = cfg_q;
`endif

    unique case (state_q)
      CS_INIT: begin
        if (is_k) begin
          if (cgs_q == 2'(CgsCount - 1)) begin
            state_d = CS_CHECK;
            cgs_d   = '0;
          end else begin
            cgs_d = cgs_q + 1'b1;
          end
        end else begin
          cgs_d = '0;
        end
      end
      CS_CHECK: begin
        if (is_r) begin
          // The /R/ seen here is octet 0 of ILAS multiframe 0.
          state_d = ILAS;
          pos_d   = PW'(1);
          mf_d    = '0;
        end else if (!is_k) begin
          state_d = CS_INIT;
        end
      end
      ILAS: begin
        pos_d = pos_next;
        if (last_pos) begin
          mf_d = mf_q + 1'b1;
        end
        ilas_fail = !octet_ok || ((pos_q == '0) && !is_r) || (last_pos && !is_a);
`ifdef JESD_RX_ILAS_CFG_CAPTURE_EN
        if ((mf_q == MW'(1)) && (pos_q == PW'(1)) && !is_q) begin
          ilas_fail = 1'b1;
        end
        if ((mf_q == MW'(1)) && (pos_q >= PW'(2)) && (pos_q <= PW'(15))) begin
          cfg_d[8 * (int'(pos_q) - 2) +: 8] = bus.rx_data;
        end
`endif
        if (ilas_fail) begin
          state_d = CS_INIT;
        end else if (last_pos && (mf_q == MW'(ILAS_MULTIFRAMES - 1))) begin
          state_d = DATA;
        end
      end
      DATA: begin
        pos_d    = pos_next;
        // Correctly placed /F/ and /A/ are the only K characters that are not errors.
        data_err = !octet_ok || (bus.rx_charisk && !replace);
        if (data_err) begin
          err_d  = err_q + 1'b1;
          good_d = '0;
        end else if (good_q == 2'd3) begin
          good_d = '0;
          if (err_q != '0) begin
            err_d = err_q - 1'b1;
          end
        end else begin
          good_d = good_q + 1'b1;
        end
        if (err_d == 2'(ErrThreshold)) begin
          state_d = CS_INIT;
        end
      end
      default: state_d = CS_INIT;
    endcase

    if ((state_d == CS_INIT) && (state_q != CS_INIT)) begin
      pos_d  = '0;
      mf_d   = '0;
      cgs_d  = '0;
      err_d  = '0;
      good_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= CS_INIT;
      pos_q        <= '0;
      mf_q         <= '0;
      cgs_q        <= '0;
      err_q        <= '0;
      good_q       <= '0;
      sync_n_q     <= 1'b0;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      frame_end_q  <= 1'b0;
      ilas_done_q  <= 1'b0;
      ilas_err_q   <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      mf_q         <= mf_d;
      cgs_q        <= cgs_d;
      err_q        <= err_d;
      good_q       <= good_d;
      sync_n_q     <= (state_d != CS_INIT);
      data_out_q   <= in_data ? restored : 8'h00;
      data_valid_q <= in_data;
      frame_end_q  <= in_data && frame_end_pos;
      ilas_done_q  <= (state_d == CS_INIT) ? 1'b0 : (in_data || ilas_done_q);
      ilas_err_q   <= ilas_fail;
      align_err_q  <= misplaced;
    end
  end

`ifdef JESD_RX_ILAS_CFG_CAPTURE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cfg_q <= '0;
    end else begin
      cfg_q <= cfg_d;
    end
  end
  assign bus.ilas_cfg = cfg_q;
`endif

  assign bus.sync_n     = sync_n_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_end  = frame_end_q;
  assign bus.ilas_done  = ilas_done_q;
  assign bus.ilas_err   = ilas_err_q;
  assign bus.align_err  = align_err_q;

endmodule

// File: tb/tb_jesd_rx_link_sync.sv
// Directed bench for jesd_rx_link_sync with F=2, K=32, four ILAS multiframes.
// Observed word layout: {sync_n, data_out, data_valid, frame_end, align_err, ilas_err, ilas_done}.
module tb_jesd_rx_link_sync;

  localparam logic [7:0] KK = 8'hBC;
  localparam logic [7:0] KR = 8'h1C;
  localparam logic [7:0] KA = 8'h7C;
  localparam logic [7:0] KQ = 8'h9C;
  localparam logic [7:0] KF = 8'hFC;

  typedef struct {
    logic [7:0]  data;
    logic        k;
    logic        derr;
    logic [13:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_fail;
  vec_t tab[$];
  logic [111:0] exp_cfg;

  jesd_rx_link_sync_if bus ();

  jesd_rx_link_sync #(
    .F                (2),
    .K                (32),
    .ILAS_MULTIFRAMES (4)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] ex(input logic s, input logic [7:0] d, input logic v,
                                     input logic fe, input logic al, input logic ie,
                                     input logic dn);
    return {s, d, v, fe, al, ie, dn};
  endfunction

  function automatic logic [13:0] obs();
    return {bus.sync_n, bus.data_out, bus.data_valid, bus.frame_end, bus.align_err,
            bus.ilas_err, bus.ilas_done};
  endfunction

  function automatic vec_t mk(input logic [7:0] d, input logic k, input logic e,
                              input logic [13:0] x);
    vec_t v;
    v.data = d;
    v.k    = k;
    v.derr = e;
    v.exp  = x;
    return v;
  endfunction

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got sync_n/out/valid/fe/align/ierr/done=%b/%h/%b/%b/%b/%b/%b required %b/%h/%b/%b/%b/%b/%b",
               name, act[13], act[12:5], act[4], act[3], act[2], act[1], act[0],
               exp[13], exp[12:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic k, input logic e);
    @(negedge clk);
    bus.rx_data       = d;
    bus.rx_charisk    = k;
    bus.rx_disperr    = e;
    bus.rx_notintable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string lbl);
    for (int i = 0; i < tab.size(); i++) begin
      drive(tab[i].data, tab[i].k, tab[i].derr);
      chk($sformatf("%s[%0d]", lbl, i), obs(), tab[i].exp);
    end
    tab.delete();
  endtask

  // Sends ILAS multiframes; multiframe bad_mf gets a data octet instead of /R/ at p=0.
  task automatic send_ilas(input int nmf, input int bad_mf);
    logic [7:0] d;
    logic       k;
    for (int m = 0; m < nmf; m++) begin
      for (int p = 0; p < 64; p++) begin
        k = 1'b0;
        d = 8'(p);
        if (p == 0) begin
          if (m == bad_mf) begin
            drive(8'h00, 1'b0, 1'b0);
            chk($sformatf("ilas_bad_r m%0d", m), obs(), ex(0, 8'h00, 0, 0, 0, 1, 0));
            return;
          end
          d = KR;
          k = 1'b1;
        end else if (p == 63) begin
          d = KA;
          k = 1'b1;
        end else if (m == 1 && p == 1) begin
          d = KQ;
          k = 1'b1;
        end else if (m == 1 && p >= 2 && p <= 15) begin
          d = 8'hA0 + 8'(p - 2);
        end
        drive(d, k, 1'b0);
        chk($sformatf("ilas m%0d p%0d", m, p), obs(), ex(1, 8'h00, 0, 0, 0, 0, 0));
      end
    end
  endtask

  initial begin
    n_vec             = 0;
    n_fail            = 0;
    rst_n             = 1'b0;
    bus.rx_data       = 8'h00;
    bus.rx_charisk    = 1'b0;
    bus.rx_disperr    = 1'b0;
    bus.rx_notintable = 1'b0;
    for (int i = 0; i < 14; i++) exp_cfg[8 * i +: 8] = 8'hA0 + 8'(i);

    repeat (2) @(posedge clk);
    #1;
    chk("reset", obs(), ex(0, 8'h00, 0, 0, 0, 0, 0));
`ifdef JESD_RX_ILAS_CFG_CAPTURE_EN
    n_vec++;
    if (bus.ilas_cfg !== 112'h0) begin
      n_fail++;
      $display("FAIL reset_cfg: got %h required 0", bus.ilas_cfg);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // CGS: broken runs keep SYNC~ low, four clean /K/ release it.
    tab.push_back(mk(KK, 1, 0, ex(0, 8'h00, 0, 0, 0, 0, 0)));
    tab.push_back(mk(KK, 1, 0, ex(0, 8'h00, 0, 0, 0, 0, 0)));
    tab.push_back(mk(KK, 1, 0, ex(0, 8'h00, 0, 0, 0, 0, 0)));
    tab.push_back(mk(8'h00, 0, 0, ex(0, 8'h00, 0, 0, 0, 0, 0)));
    tab.push_back(mk(KK, 1, 0, ex(0, 8'h00, 0, 0, 0, 0, 0)));
    tab.push_back(mk(KK, 1, 0, ex(0, 8'h00, 0, 0, 0, 0, 0)));
    tab.push_back(mk(KK, 1, 0, ex(0, 8'h00, 0, 0, 0, 0, 0)));
    tab.push_back(mk(KK, 1, 1, ex(0, 8'h00, 0, 0, 0, 0, 0)));
    tab.push_back(mk(KK, 1, 0, ex(0, 8'h00, 0, 0, 0, 0, 0)));
    tab.push_back(mk(KK, 1, 0, ex(0, 8'h00, 0, 0, 0, 0, 0)));
    tab.push_back(mk(KK, 1, 0, ex(0, 8'h00, 0, 0, 0, 0, 0)));
    tab.push_back(mk(KK, 1, 0, ex(1, 8'h00, 0, 0, 0, 0, 0)));
    run_table("cgs");

    send_ilas(4, -1);

`ifdef JESD_RX_ILAS_CFG_CAPTURE_EN
    n_vec++;
    if (bus.ilas_cfg !== exp_cfg) begin
      n_fail++;
      $display("FAIL ilas_cfg: got %h required %h", bus.ilas_cfg, exp_cfg);
    end
`endif

    // First data frames: pass-through and /F/ replacement at a frame end.
    tab.push_back(mk(8'h01, 0, 0, ex(1, 8'h01, 1, 0, 0, 0, 1)));
    tab.push_back(mk(8'h02, 0, 0, ex(1, 8'h02, 1, 1, 0, 0, 1)));
    tab.push_back(mk(8'h10, 0, 0, ex(1, 8'h10, 1, 0, 0, 0, 1)));
    tab.push_back(mk(8'h55, 0, 0, ex(1, 8'h55, 1, 1, 0, 0, 1)));
    tab.push_back(mk(8'h20, 0, 0, ex(1, 8'h20, 1, 0, 0, 0, 1)));
    tab.push_back(mk(KF, 1, 0, ex(1, 8'h55, 1, 1, 0, 0, 1)));
    run_table("data1");

    for (int p = 6; p < 63; p++) begin
      drive(8'(p), 1'b0, 1'b0);
      chk($sformatf("fill p%0d", p), obs(), ex(1, 8'(p), 1, (p % 2) == 1, 0, 0, 1));
    end
    // /A/ at the multiframe end restores the octet from p=61.
    drive(KA, 1'b1, 1'b0);
    chk("a_replace p63", obs(), ex(1, 8'h3D, 1, 1, 0, 0, 1));

    // Error counting: one error healed by four good octets, then three more errors.
    tab.push_back(mk(KF, 1, 0, ex(1, 8'h3D, 1, 0, 1, 0, 1)));
    tab.push_back(mk(8'h31, 0, 0, ex(1, 8'h31, 1, 1, 0, 0, 1)));
    tab.push_back(mk(8'h32, 0, 0, ex(1, 8'h32, 1, 0, 0, 0, 1)));
    tab.push_back(mk(8'h33, 0, 0, ex(1, 8'h33, 1, 1, 0, 0, 1)));
    tab.push_back(mk(8'h34, 0, 0, ex(1, 8'h34, 1, 0, 0, 0, 1)));
    tab.push_back(mk(8'h35, 0, 0, ex(1, 8'h35, 1, 1, 0, 0, 1)));
    tab.push_back(mk(KA, 1, 0, ex(1, 8'h35, 1, 0, 1, 0, 1)));
    tab.push_back(mk(8'h36, 0, 0, ex(1, 8'h36, 1, 1, 0, 0, 1)));
    tab.push_back(mk(KK, 1, 0, ex(1, KK, 1, 0, 0, 0, 1)));
    tab.push_back(mk(8'h37, 0, 0, ex(1, 8'h37, 1, 1, 0, 0, 1)));
    tab.push_back(mk(KF, 1, 0, ex(0, 8'h37, 1, 0, 1, 0, 0)));
    tab.push_back(mk(KK, 1, 0, ex(0, 8'h00, 0, 0, 0, 0, 0)));
    tab.push_back(mk(KK, 1, 0, ex(0, 8'h00, 0, 0, 0, 0, 0)));
    tab.push_back(mk(KK, 1, 0, ex(0, 8'h00, 0, 0, 0, 0, 0)));
    tab.push_back(mk(KK, 1, 0, ex(1, 8'h00, 0, 0, 0, 0, 0)));
    run_table("errs");

    // Missing /R/ at the start of ILAS multiframe 2.
    send_ilas(4, 2);
    drive(8'h00, 1'b0, 1'b0);
    chk("after_ilas_err", obs(), ex(0, 8'h00, 0, 0, 0, 0, 0));

    // Asynchronous reset in the middle of ILAS.
    for (int i = 0; i < 4; i++) drive(KK, 1'b1, 1'b0);
    drive(KR, 1'b1, 1'b0);
    for (int i = 1; i < 6; i++) drive(8'(i), 1'b0, 1'b0);
    chk("pre_reset", obs(), ex(1, 8'h00, 0, 0, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", obs(), ex(0, 8'h00, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
